// File: rtl/syncn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syncn_pkg
// Description : Shared definitions for the SYNC~ generator: FSM state
//               encoding, default parameter values, counter widths and a
//               saturating 4-bit increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package syncn_pkg;

  // Link-receiver FSM states (explicit 3-bit encoding).
  typedef enum logic [2:0] {
    ST_CGS       = 3'd0,
    ST_WAIT_LMFC = 3'd1,
    ST_DATA      = 3'd2,
    ST_ERR       = 3'd3,
    ST_REINIT    = 3'd4
  } syncn_state_e;

  localparam int K_CNT_DEF         = 4;
  localparam int ERR_FRAMES_DEF    = 2;
  localparam int REINIT_FRAMES_DEF = 5;

  // Lane counters hold up to 7 (largest legal K_CNT); frame counter is 4 bits.
  localparam int KCNT_W = 3;
  localparam int FCNT_W = 4;

  // Frame counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [FCNT_W-1:0] sat_inc_fcnt(input logic [FCNT_W-1:0] v);
    return (v == {FCNT_W{1'b1}}) ? v : v + {{(FCNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/syncn_lane_kcnt.sv
`default_nettype none
// ============================================================================
// Module      : syncn_lane_kcnt
// Description : Per-lane saturating count of consecutive K28.5 frames.
//               On a frame tick the count increments (saturating at K_CNT)
//               when the lane saw only K28.5, otherwise it clears. It holds
//               between ticks. i_clr forces the count to zero.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               i_clr      - synchronous clear (link re-init)
//               i_tick     - frame tick qualifier
//               i_k        - lane received only K28.5 this frame
//               o_full     - count has reached K_CNT
// Revision    : 1.0 - initial release
// ============================================================================
module syncn_lane_kcnt
  import syncn_pkg::*;
#(
  parameter int K_CNT = K_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_tick,
  input  logic i_k,
  output logic o_full
);

  localparam logic [KCNT_W-1:0] C_K_MAX = KCNT_W'(K_CNT);

  logic [KCNT_W-1:0] cnt_q;
  logic [KCNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_tick) begin
      if (!i_k) begin
        cnt_d = '0;
      end else if (cnt_q != C_K_MAX) begin
        cnt_d = cnt_q + {{(KCNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_full = (cnt_q == C_K_MAX);

endmodule
`default_nettype wire

// File: rtl/syncn_generator.sv
`default_nettype none
// ============================================================================
// Module      : syncn_generator
// Description : JESD204B-style receiver SYNC~ generator. Tracks code-group
//               synchronisation per lane, releases SYNC~ on the LMFC boundary
//               once all lanes are stable, reports receive errors as a short
//               SYNC~ low pulse and handles link re-initialisation requests.
// Macro       : SYNCN_ERR_REPORT_EN - when defined, the ERR state and i_err
//               handling are built; otherwise i_err is unused.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               frame_clk    - frame tick qualifier (sampled on clk)
//               i_lmfc_edge  - one-clk pulse at each LMFC boundary
//               i_k_char[L]  - lane saw only K28.5 this frame
//               i_reinit     - re-initialisation request
//               i_err        - receive error event
//               o_sync_n     - registered SYNC~ (high only in DATA)
//               o_cgs_done   - registered, high in DATA and ERR
// Revision    : 1.0 - initial release
// ============================================================================
module syncn_generator
  import syncn_pkg::*;
#(
  parameter int L             = 1,
  parameter int K_CNT         = K_CNT_DEF,
  parameter int ERR_FRAMES    = ERR_FRAMES_DEF,
  parameter int REINIT_FRAMES = REINIT_FRAMES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_clk,
  input  logic         i_lmfc_edge,
  input  logic [L-1:0] i_k_char,
  input  logic         i_reinit,
  input  logic         i_err,
  output logic         o_sync_n,
  output logic         o_cgs_done
);

  // ---------------------------------------------------------------------------
  // Parameter range checks (fail elaboration on illegal configurations)
  // ---------------------------------------------------------------------------
  if (L < 1 || L > 8) begin : g_chk_l
    $error("syncn_generator: L out of range 1..8");
  end
  if (K_CNT < 1 || K_CNT > 7) begin : g_chk_k_cnt
    $error("syncn_generator: K_CNT out of range 1..7");
  end
  if (ERR_FRAMES < 1 || ERR_FRAMES > 3) begin : g_chk_err_frames
    $error("syncn_generator: ERR_FRAMES out of range 1..3");
  end
  if (REINIT_FRAMES < 5 || REINIT_FRAMES > 15) begin : g_chk_reinit_frames
    $error("syncn_generator: REINIT_FRAMES out of range 5..15");
  end

  localparam logic [FCNT_W-1:0] C_REINIT_FR = FCNT_W'(REINIT_FRAMES);

  syncn_state_e      state_q, state_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              sync_n_q, sync_n_d;
  logic              cgs_done_q, cgs_done_d;

  logic [L-1:0]      lane_full;
  logic              all_full;
  logic              lane_miss;
  logic              lane_clr;
  logic [FCNT_W-1:0] frame_inc;

  // Lane counters are held at zero for the whole REINIT period.
  assign lane_clr  = (state_q == ST_REINIT);
  assign all_full  = &lane_full;
  // A tick where any lane saw a non-K character breaks synchronisation.
  assign lane_miss = frame_clk && !(&i_k_char);
  assign frame_inc = sat_inc_fcnt(frame_cnt_q);

  for (genvar l = 0; l < L; l++) begin : g_lane
    syncn_lane_kcnt #(
      .K_CNT (K_CNT)
    ) u_lane_kcnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (lane_clr),
      .i_tick (frame_clk),
      .i_k    (i_k_char[l]),
      .o_full (lane_full[l])
    );
  end

`ifdef SYNCN_ERR_REPORT_EN
  localparam logic [FCNT_W-1:0] C_ERR_FR = FCNT_W'(ERR_FRAMES);
`else
  logic unused_err;
  assign unused_err = i_err;
`endif

  // ---------------------------------------------------------------------------
  // Next-state, frame counter and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CGS: begin
        if (all_full) state_d = ST_WAIT_LMFC;
      end
      ST_WAIT_LMFC: begin
        // Losing a lane beats a coincident LMFC edge.
        if (lane_miss)        state_d = ST_CGS;
        else if (i_lmfc_edge) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (i_reinit) state_d = ST_REINIT;
`ifdef SYNCN_ERR_REPORT_EN
        else if (i_err) state_d = ST_ERR;
`endif
      end
`ifdef SYNCN_ERR_REPORT_EN
      ST_ERR: begin
        // frame_inc is the tick count including the current tick.
        if (i_reinit)                             state_d = ST_REINIT;
        else if (frame_clk && frame_inc >= C_ERR_FR) state_d = ST_DATA;
      end
`endif
      ST_REINIT: begin
        // Once the minimum time has elapsed the counter saturates, so the
        // first tick with i_reinit low releases the link.
        if (frame_clk && frame_inc >= C_REINIT_FR && !i_reinit) state_d = ST_CGS;
      end
      default: state_d = ST_CGS;
    endcase

    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = '0;
    end else if (frame_clk && (state_q == ST_ERR || state_q == ST_REINIT)) begin
      frame_cnt_d = frame_inc;
    end

    // Outputs are registered from the next state so they move with it.
    sync_n_d   = (state_d == ST_DATA);
    cgs_done_d = (state_d == ST_DATA) || (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CGS;
      frame_cnt_q <= '0;
      sync_n_q    <= 1'b0;
      cgs_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      sync_n_q    <= sync_n_d;
      cgs_done_q  <= cgs_done_d;
    end
  end

  assign o_sync_n   = sync_n_q;
  assign o_cgs_done = cgs_done_q;

endmodule
`default_nettype wire

// File: tb/tb_syncn_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_syncn_generator
// Description : Self-checking bench for syncn_generator (L=2). A reference
//               model computes the expected outputs each cycle and queues
//               them; a monitor pops and compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syncn_generator;

  localparam int L  = 2;
  localparam int KC = 4;
  localparam int EF = 2;
  localparam int RF = 5;
`ifdef SYNCN_ERR_REPORT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Model phases (bench-local naming).
  localparam int M_CGS = 0, M_WAIT = 1, M_DATA = 2, M_ERR = 3, M_REINIT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_clk;
  logic         i_lmfc_edge;
  logic [L-1:0] i_k_char;
  logic         i_reinit;
  logic         i_err;
  logic         o_sync_n;
  logic         o_cgs_done;

  always #5 clk = ~clk;

  syncn_generator #(
    .L             (L),
    .K_CNT         (KC),
    .ERR_FRAMES    (EF),
    .REINIT_FRAMES (RF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_clk   (frame_clk),
    .i_lmfc_edge (i_lmfc_edge),
    .i_k_char    (i_k_char),
    .i_reinit    (i_reinit),
    .i_err       (i_err),
    .o_sync_n    (o_sync_n),
    .o_cgs_done  (o_cgs_done)
  );

  typedef struct packed {
    logic sync_n;
    logic cgs_done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model state
  int m_phase = M_CGS;
  int m_run[L];
  int m_left  = 0;

  task automatic model_step();
    int  nxt;
    bit  all_k;
    exp_t e;
    if (rst) begin
      m_phase = M_CGS;
      m_left  = 0;
      for (int l = 0; l < L; l++) m_run[l] = 0;
    end else begin
      nxt = m_phase;
      case (m_phase)
        M_CGS: begin
          all_k = 1'b1;
          for (int l = 0; l < L; l++) if (m_run[l] != KC) all_k = 1'b0;
          if (all_k) nxt = M_WAIT;
        end
        M_WAIT: begin
          if (frame_clk && (i_k_char != {L{1'b1}})) nxt = M_CGS;
          else if (i_lmfc_edge) nxt = M_DATA;
        end
        M_DATA: begin
          if (i_reinit) begin
            nxt = M_REINIT; m_left = RF;
          end else if (ERR_EN && i_err) begin
            nxt = M_ERR; m_left = EF;
          end
        end
        M_ERR: begin
          if (i_reinit) begin
            nxt = M_REINIT; m_left = RF;
          end else if (frame_clk) begin
            m_left = m_left - 1;
            if (m_left == 0) nxt = M_DATA;
          end
        end
        M_REINIT: begin
          if (frame_clk) begin
            if (m_left > 0) m_left = m_left - 1;
            if (m_left == 0 && !i_reinit) nxt = M_CGS;
          end
        end
        default: nxt = M_CGS;
      endcase
      // Lane run lengths: zeroed throughout REINIT, else track consecutive K frames.
      for (int l = 0; l < L; l++) begin
        if (m_phase == M_REINIT) m_run[l] = 0;
        else if (frame_clk) m_run[l] = i_k_char[l] ? ((m_run[l] < KC) ? m_run[l] + 1 : KC) : 0;
      end
      m_phase = nxt;
    end
    e.sync_n   = (m_phase == M_DATA);
    e.cgs_done = (m_phase == M_DATA) || (m_phase == M_ERR);
    exp_q.push_back(e);
  endtask

  // Model: samples inputs at each active edge and queues the expected response.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares the DUT outputs just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (o_sync_n !== e.sync_n || o_cgs_done !== e.cgs_done) begin
          errors++;
          $display("FAIL outputs cycle %0d: got sync_n=%b cgs_done=%b expected sync_n=%b cgs_done=%b",
                   cycle, o_sync_n, o_cgs_done, e.sync_n, e.cgs_done);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit fc_t = 1'b0;

  task automatic cyc(input bit fc, input bit lm, input logic [L-1:0] k,
                     input bit ri, input bit er, input bit rs);
    @(negedge clk);
    frame_clk   = fc;
    i_lmfc_edge = lm;
    i_k_char    = k;
    i_reinit    = ri;
    i_err       = er;
    rst         = rs;
  endtask

  // One cycle with frame_clk alternating.
  task automatic step(input bit lm, input logic [L-1:0] k,
                      input bit ri, input bit er, input bit rs);
    fc_t = ~fc_t;
    cyc(fc_t, lm, k, ri, er, rs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
  endtask

  // Make the next step carry a frame tick.
  task automatic align_tick();
    if (fc_t) idle(1);
  endtask

  initial begin
    int reinit_hold;
    bit fc_r, ri, er, rs, lm;
    logic [L-1:0] kr;

    rst = 1'b1; frame_clk = 1'b0; i_lmfc_edge = 1'b0;
    i_k_char = '0; i_reinit = 1'b0; i_err = 1'b0;

    // Reset held for a few cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    // CGS on both lanes, then LMFC pulse releases SYNC~.
    idle(12);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Single-cycle error aligned with a frame tick.
    align_tick();
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0);
    idle(8);

    // Error and re-init together: re-init wins.
    step(1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
    idle(16);

    // Back to DATA, then reset in the middle of an error report.
    idle(4);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(2);
    align_tick();
    step(1'b0, 2'b11, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Lane 1 drops K on an early frame; periodic LMFC pulses.
    for (int i = 0; i < 24; i++)
      step((i % 8) == 7, (i == 5) ? 2'b01 : 2'b11, 1'b0, 1'b0, 1'b0);

    // Long re-init request held past the minimum duration.
    for (int i = 0; i < 20; i++) step(1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
    idle(14);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(3);

    // WAIT_LMFC with a lane miss coinciding with an LMFC edge.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(10);
    align_tick();
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(12);

    // Randomised traffic.
    reinit_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      fc_r = ($urandom_range(0, 9) < 7) ? ~fc_t : 1'($urandom_range(0, 1));
      fc_t = fc_r;
      kr[0] = ($urandom_range(0, 99) < 94);
      kr[1] = ($urandom_range(0, 99) < 94);
      lm = ($urandom_range(0, 11) == 0);
      er = ($urandom_range(0, 19) == 0);
      if (reinit_hold > 0) begin
        reinit_hold--;
        ri = 1'b1;
      end else if ($urandom_range(0, 79) == 0) begin
        reinit_hold = $urandom_range(0, 14);
        ri = 1'b1;
      end else begin
        ri = 1'b0;
      end
      rs = ($urandom_range(0, 599) == 0);
      cyc(fc_r, lm, kr, ri, er, rs);
    end

    idle(3);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/syncn_generator.md
SYNCN_GENERATOR -- requirements
Module: syncn_generator

Interface
REQ-001 SHALL have parameter L, default 1, the number of lanes (1..8).
REQ-002 SHALL have parameter K_CNT, default 4, the consecutive K28.5 frames per lane required to end CGS (1..7).
REQ-003 SHALL have parameter ERR_FRAMES, default 2, the SYNC~ low duration of an error report in frames (1..3).
REQ-004 SHALL have parameter REINIT_FRAMES, default 5, the minimum SYNC~ low duration of a re-init request in frames (5..15).
REQ-005 SHALL have port clk, input, 1 bit: device clock, the only clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port frame_clk, input, 1 bit: frame qualifier sampled on clk; each clk edge with frame_clk=1 is one frame tick.
REQ-008 SHALL have port i_lmfc_edge, input, 1 bit: one-clk pulse at each LMFC boundary.
REQ-009 SHALL have port i_k_char, input, L bits: lane l received only K28.5 in the current frame; valid on frame ticks.
REQ-010 SHALL have port i_reinit, input, 1 bit: link re-initialization request.
REQ-011 SHALL have port i_err, input, 1 bit: receive error event (disparity / not-in-table).
REQ-012 SHALL have port o_sync_n, output, 1 bit: SYNC~ to transmitter, registered.
REQ-013 SHALL have port o_cgs_done, output, 1 bit: high in DATA and ERR states, registered.

Function
REQ-014 SHALL implement the FSM states CGS, WAIT_LMFC, DATA, ERR and REINIT; o_sync_n=0 in CGS, WAIT_LMFC, ERR and REINIT, and o_sync_n=1 in DATA.
REQ-015 SHALL make all outputs registered, with a change visible on the clk edge after the triggering cycle.
REQ-016 SHALL keep per-lane saturating counters: on a frame tick, increment the counter if i_k_char[l]=1 (saturating at K_CNT), else clear it to 0; counters SHALL hold between frame ticks.
REQ-017 In CGS, SHALL go to WAIT_LMFC when all L counters equal K_CNT.
REQ-018 In WAIT_LMFC, SHALL go to DATA on i_lmfc_edge=1; a frame tick with any i_k_char bit 0 SHALL return to CGS, and this takes priority over a coincident LMFC edge.
REQ-019 In DATA, i_reinit=1 SHALL enter REINIT; otherwise i_err=1 SHALL enter ERR; if both are asserted in the same cycle, REINIT SHALL win.
REQ-020 ERR SHALL hold for exactly ERR_FRAMES frame ticks, counting from the first tick after entry, then return to DATA.
REQ-021 In ERR, i_err SHALL be ignored (no queuing, no extension), and i_reinit SHALL go to REINIT.
REQ-022 REINIT SHALL clear all lane counters, hold for REINIT_FRAMES frame ticks, then go to CGS; i_reinit still high at expiry SHALL keep the block in REINIT.
REQ-023 SHALL ignore i_err in CGS, WAIT_LMFC and REINIT.
REQ-024 SHALL count frames with 4-bit counters without wrap; parameters outside their ranges SHALL fail elaboration.

Reset
REQ-025 While rst=1, SHALL be in state CGS with o_sync_n=0, o_cgs_done=0, all lane counters 0 and the frame counter 0.
REQ-026 rst asserted mid-ERR or mid-REINIT SHALL abort that state immediately to CGS.

Configuration
REQ-027 With SYNCN_ERR_REPORT_EN defined, SHALL compile the ERR state and i_err handling.
REQ-028 Without SYNCN_ERR_REPORT_EN, SHALL leave i_err unused, make ERR unreachable, and never pulse o_sync_n in DATA except via REINIT.

Structure
REQ-029 Package syncn_pkg SHALL hold the FSM state encoding and the constants K_CNT_DEF=4, ERR_FRAMES_DEF=2 and REINIT_FRAMES_DEF=5.
REQ-030 The per-lane saturating counter SHALL be sub-module syncn_lane_kcnt, instantiated L times via generate.

Verification
REQ-031 L=2, frame_clk alternating, both lanes K for 4 frames, LMFC pulse at frame 6 -> o_sync_n and o_cgs_done rise 1 clk after the LMFC pulse.
REQ-032 L=2, lane1 i_k_char=0 at frame 3 -> no WAIT_LMFC until 4 further consecutive K frames on lane1; o_sync_n stays 0.
REQ-033 In DATA, single-cycle i_err (macro on) -> o_sync_n low for exactly 2 frame ticks (4 clk), o_cgs_done stays 1, then o_sync_n=1.
REQ-034 In DATA, i_err and i_reinit asserted in the same cycle -> o_sync_n low for at least 5 frames, o_cgs_done=0, CGS re-entered, counters 0.
REQ-035 rst pulsed during ERR -> next clk o_sync_n=0, o_cgs_done=0, state CGS.
REQ-036 Macro off, i_err pulses in DATA -> o_sync_n stays 1.
